// File: rtl/gelato_register_bank_responder.sv
// gelato_register_bank_responder
// Responder side of the register collect protocol: takes one multi-operand
// request, grants at most one operand per register bank, reads the banked
// 1R1W storage and returns a single response. Losing operands are dropped.
// Optional feature macro: GELATO_RF_ZERO_REG_EN (address 0 hard-wired to zero).
module gelato_register_bank_responder #(
    parameter int unsigned COLLECTOR_SIZE = 4,
    parameter int unsigned BANK_NUM       = 4,
    parameter int unsigned REG_ADDR_W     = 5,
    parameter int unsigned DATA_W         = 32,
    localparam int unsigned BW            = $clog2(BANK_NUM),
    localparam int unsigned CW            = $clog2(COLLECTOR_SIZE),
    localparam int unsigned OPS           = 4,
    localparam int unsigned IW            = 2
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 req_valid,
    output logic                                 req_ready,
    input  logic [COLLECTOR_SIZE-1:0]            req_entry_valid,
    input  logic [COLLECTOR_SIZE*CW-1:0]         req_collector_num,
    input  logic [COLLECTOR_SIZE*OPS*REG_ADDR_W-1:0] req_reg_num,
    input  logic [COLLECTOR_SIZE*OPS-1:0]        req_reg_valid,
    output logic                                 rsp_valid,
    input  logic                                 rsp_ready,
    output logic [BANK_NUM-1:0]                  rsp_data_valid,
    output logic [BANK_NUM*CW-1:0]               rsp_collector_idx,
    output logic [BANK_NUM*IW-1:0]               rsp_reg_index,
    output logic [BANK_NUM*DATA_W-1:0]           rsp_data,
    input  logic                                 wb_valid,
    input  logic [REG_ADDR_W-1:0]                wb_reg,
    input  logic [DATA_W-1:0]                    wb_data
);

    localparam int unsigned RW   = REG_ADDR_W - BW;
    localparam int unsigned ROWS = 1 << RW;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                  state;

    // Grant latched at accept time, consumed by the read stage
    logic [BANK_NUM-1:0]     sel_valid;
    logic [BANK_NUM*CW-1:0]  sel_coll;
    logic [BANK_NUM*IW-1:0]  sel_idx;
    logic [BANK_NUM*RW-1:0]  sel_row;

    logic [BANK_NUM-1:0]     arb_valid;
    logic [BANK_NUM*CW-1:0]  arb_coll;
    logic [BANK_NUM*IW-1:0]  arb_idx;
    logic [BANK_NUM*RW-1:0]  arb_row;

    logic [DATA_W-1:0]       mem [BANK_NUM][ROWS];
    logic [DATA_W-1:0]       rd_word [BANK_NUM];

    logic [BW-1:0]           wb_bank;
    logic [RW-1:0]           wb_row;
    logic                    wb_en;
    logic                    unused_op0;

    assign wb_bank = wb_reg[BW-1:0];
    assign wb_row  = wb_reg[REG_ADDR_W-1:BW];

`ifdef GELATO_RF_ZERO_REG_EN
    assign wb_en = wb_valid && (wb_reg != '0);
`else
    assign wb_en = wb_valid;
`endif

    // Operand field 0 of every slot carries no operand
    always_comb begin
        unused_op0 = 1'b0;
        for (int i = 0; i < int'(COLLECTOR_SIZE); i++) begin
            unused_op0 = unused_op0 ^ (^req_reg_num[(i*OPS)*REG_ADDR_W +: REG_ADDR_W])
                                    ^ req_reg_valid[i*OPS];
        end
    end

    // Per-bank priority pick: first live operand in slot-major, operand-minor order
    always_comb begin
        arb_valid = '0;
        arb_coll  = '0;
        arb_idx   = '0;
        arb_row   = '0;
        for (int b = 0; b < int'(BANK_NUM); b++) begin
            for (int i = 0; i < int'(COLLECTOR_SIZE); i++) begin
                for (int j = 1; j < int'(OPS); j++) begin
                    if (!arb_valid[b] && req_entry_valid[i] && req_reg_valid[i*OPS+j] &&
                        (req_reg_num[(i*OPS+j)*REG_ADDR_W +: BW] == BW'(b))) begin
                        arb_valid[b]          = 1'b1;
                        arb_coll[b*CW +: CW]  = req_collector_num[i*CW +: CW];
                        arb_idx[b*IW +: IW]   = IW'(j);
                        arb_row[b*RW +: RW]   = req_reg_num[(i*OPS+j)*REG_ADDR_W+BW +: RW];
                    end
                end
            end
        end
    end

    // Bank read port with write-first bypass of a same-cycle writeback
    always_comb begin
        for (int b = 0; b < int'(BANK_NUM); b++) begin
            rd_word[b] = mem[b][sel_row[b*RW +: RW]];
            if (wb_en && (wb_bank == BW'(b)) && (wb_row == sel_row[b*RW +: RW])) begin
                rd_word[b] = wb_data;
            end
`ifdef GELATO_RF_ZERO_REG_EN
            if ((b == 0) && (sel_row[RW-1:0] == '0)) begin
                rd_word[b] = '0;
            end
`endif
        end
    end

    // Register storage write port, independent of the request FSM
    always_ff @(posedge clk) begin
        if (wb_en) begin
            mem[wb_bank][wb_row] <= wb_data;
        end
    end

    // Request/response sequencing with registered handshake and response fields
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            req_ready         <= 1'b1;
            rsp_valid         <= 1'b0;
            rsp_data_valid    <= '0;
            rsp_collector_idx <= '0;
            rsp_reg_index     <= '0;
            rsp_data          <= '0;
            sel_valid         <= '0;
            sel_coll          <= '0;
            sel_idx           <= '0;
            sel_row           <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        sel_valid <= arb_valid;
                        sel_coll  <= arb_coll;
                        sel_idx   <= arb_idx;
                        sel_row   <= arb_row;
                        req_ready <= 1'b0;
                        state     <= READ;
                    end
                end
                READ: begin
                    rsp_valid         <= 1'b1;
                    rsp_data_valid    <= sel_valid;
                    rsp_collector_idx <= sel_coll;
                    rsp_reg_index     <= sel_idx;
                    for (int b = 0; b < int'(BANK_NUM); b++) begin
                        rsp_data[b*DATA_W +: DATA_W] <= sel_valid[b] ? rd_word[b] : '0;
                    end
                    state <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid         <= 1'b0;
                        rsp_data_valid    <= '0;
                        rsp_collector_idx <= '0;
                        rsp_reg_index     <= '0;
                        rsp_data          <= '0;
                        req_ready         <= 1'b1;
                        state             <= IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
